tl_write_back_reg: RTL and testbench
====================================

Name: tl_write_back_reg

Overview:
Registered, parametrised write-back stage for the MIPS pipeline. It contains the MEM/WB pipeline register, with stall and flush control, and performs sub-word load extraction (LB/LBU/LH/LHU/LW). It selects the register-file write data from ALU, memory or link (PC+8). It also suppresses writes to register 0, flags misaligned loads, counts retired instructions and latches program halt. It sits between the memory stage and the register file/forwarding unit.

Parameters:
LEN, 32, datapath width (must be 32 for sub-word extraction)
NB_ADDRESS_REGISTROS, 5, register address width
NB_WB_SEL, 2, write-data source select width
NB_LOAD_TYPE, 3, load-type code width
NB_COUNT, 32, retired-instruction counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  MEM stage presents a real instruction
i_stall  in  1  hold MEM/WB register contents
i_flush  in  1  load a bubble into MEM/WB
i_read_data  in  LEN  raw word from data memory
i_result_alu  in  LEN  ALU result; bits [1:0] are the load byte offset
i_pc_plus8  in  LEN  link value for JAL/JALR
i_wb_sel  in  NB_WB_SEL  00 ALU, 01 MEM, 10 LINK, 11 reserved (behaves as ALU)
i_load_type  in  NB_LOAD_TYPE  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others as LW
i_RegWrite  in  1  instruction writes the register file
i_write_reg  in  NB_ADDRESS_REGISTROS  destination register
i_halt  in  1  instruction is HALT
o_write_data  out  LEN  data to register file/forwarding
o_write_reg  out  NB_ADDRESS_REGISTROS  destination register
o_RegWrite  out  1  qualified write enable
o_valid  out  1  WB holds a real instruction
o_misaligned  out  1  current WB load was misaligned (write suppressed)
o_halted  out  1  sticky, program halted
o_retired_count  out  NB_COUNT  retired instruction count, saturating

Behaviour:
- Reset (async, i_rst_n=0): all MEM/WB fields cleared, o_valid=0, o_RegWrite=0, o_write_data=0, o_write_reg=0, o_misaligned=0, o_halted=0, o_retired_count=0, FSM=RUN. Release is synchronous to i_clk.
- Latency: 1 cycle. Inputs are captured on the rising edge. All outputs are derived from registered fields; the extraction/mux path after the register is combinational.
- Register update priority per edge: i_flush (load bubble: valid=0, RegWrite=0, halt=0) > i_stall (hold) > capture the inputs.
- A bubble or invalid entry forces o_RegWrite=0. o_write_data/o_write_reg are don't-care but must not be X.
- Load extraction, using offset = registered i_result_alu[1:0], applies only when wb_sel=MEM:
  - LB/LBU: byte at offset (offset 0 = bits [7:0]), sign-/zero-extended to LEN.
  - LH/LHU: halfword at offset[1] (0 = bits [15:0]), sign-/zero-extended.
  - LW: full word.
- Misaligned load: halfword with offset[0]=1, or word with offset≠0, while wb_sel=MEM. Result: o_misaligned=1, o_RegWrite=0, o_write_data = raw word.
- o_RegWrite = valid & RegWrite & (write_reg≠0) & ~misaligned & ~o_halted.
- FSM states:
  - RUN -> HALTED when a valid halt entry is in WB (registered the cycle after capture).
  - HALTED -> RUN only on reset.
  - In HALTED, o_RegWrite=0 and the counter freezes. The HALT itself is counted once.
- Counter: +1 per cycle with valid=1 in RUN, including a stall-held entry only on its first WB cycle (an internal "counted" flag is cleared on each new capture). Saturates at all-ones with no wrap.
- Stall: the entry is held and outputs are stable. The register file may be rewritten with the same value; this is harmless.
- Simultaneous flush+stall: flush wins. Simultaneous halt+RegWrite in one entry: the write is performed and halted is set the next cycle.

Decomposition:
- Shared package wb_pkg holds the WB_SEL_ALU/MEM/LINK codes, the LOAD_LW/LB/LBU/LH/LHU codes and the FSM state encoding (RUN/HALTED).
- One sub-module, load_extract (combinational): raw word, offset and load type in; extended data and misaligned flag out.
- The existing mux module may be reused for the source select.

Test Plan:
- Reset mid-run with o_halted=1 and count=7: assert i_rst_n=0 -> all outputs 0 immediately (asynchronous); the following instructions run normally.
- LB, raw=0x12_34_80_FF, offset 1, write_reg=3 -> next cycle o_write_data=0xFFFF_FF80, o_RegWrite=1. The same case with LBU -> 0x0000_0080.
- LH at offset 2 on raw 0x8001_0000 -> 0xFFFF_8001. LH at offset 1 -> o_misaligned=1, o_RegWrite=0.
- JAL with wb_sel=10, pc_plus8=0x0000_0048, write_reg=31 -> o_write_data=0x48, o_RegWrite=1. An ALU op to write_reg=0 -> o_RegWrite=0.
- Stall 3 cycles then flush: outputs held for 3 cycles, then o_valid=0 and o_RegWrite=0. Count increments once for the held instruction.
- HALT after 5 valid instructions -> o_halted=1 the cycle after HALT reaches WB and count=6. Later valid ALU writes give o_RegWrite=0 and the count stays 6.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB write-back stage.
//   WB_SEL_*   : register-file write-data source select codes
//   LOAD_*     : load-type codes used by sub-word extraction
//   wb_state_e : write-back control FSM state
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LB  = 3'b001;
    localparam logic [2:0] LOAD_LBU = 3'b010;
    localparam logic [2:0] LOAD_LH  = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;

    typedef enum logic {
        StRun    = 1'b0,
        StHalted = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// Combinational sub-word load extraction.
// Ports:
//   raw_word_i   : word read from data memory
//   offset_i     : byte offset within the word (address bits [1:0])
//   load_type_i  : LW/LB/LBU/LH/LHU code, unknown codes behave as LW
//   data_o       : extended load data, or the raw word when misaligned
//   misaligned_o : access is not naturally aligned for its size
module load_extract
    import wb_pkg::*;
#(
    parameter int unsigned LEN          = 32,
    parameter int unsigned NB_LOAD_TYPE = 3
) (
    input  logic [LEN-1:0]          raw_word_i,
    input  logic [1:0]              offset_i,
    input  logic [NB_LOAD_TYPE-1:0] load_type_i,
    output logic [LEN-1:0]          data_o,
    output logic                    misaligned_o
);

    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [LEN-1:0] ext_data;

    always_comb begin
        byte_sel = raw_word_i[7:0];
        unique case (offset_i)
            2'd0: byte_sel = raw_word_i[7:0];
            2'd1: byte_sel = raw_word_i[15:8];
            2'd2: byte_sel = raw_word_i[23:16];
            2'd3: byte_sel = raw_word_i[31:24];
            default: byte_sel = raw_word_i[7:0];
        endcase
        half_sel = offset_i[1] ? raw_word_i[31:16] : raw_word_i[15:0];
    end

    always_comb begin
        ext_data     = raw_word_i;
        misaligned_o = 1'b0;
        case (load_type_i)
            LOAD_LB:  ext_data = {{(LEN-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: ext_data = {{(LEN-8){1'b0}}, byte_sel};
            LOAD_LH: begin
                ext_data     = {{(LEN-16){half_sel[15]}}, half_sel};
                misaligned_o = offset_i[0];
            end
            LOAD_LHU: begin
                ext_data     = {{(LEN-16){1'b0}}, half_sel};
                misaligned_o = offset_i[0];
            end
            default: misaligned_o = (offset_i != 2'd0);
        endcase
        // A misaligned access passes the raw word through unchanged.
        data_o = misaligned_o ? raw_word_i : ext_data;
    end

endmodule

// File: rtl/tl_write_back_reg.sv
// MEM/WB pipeline register and write-back stage.
// Ports:
//   i_clk, i_rst_n       : clock (rising edge), async active-low reset
//   i_valid/i_stall/...  : MEM-stage instruction and pipeline control
//   i_read_data          : raw memory word; i_result_alu[1:0] is the byte offset
//   i_pc_plus8           : link value for JAL/JALR
//   i_wb_sel/i_load_type : data source select and load type
//   i_RegWrite/i_write_reg/i_halt : destination control and HALT marker
//   o_write_data/o_write_reg/o_RegWrite : register-file write port
//   o_valid, o_misaligned, o_halted, o_retired_count : status
module tl_write_back_reg
    import wb_pkg::*;
#(
    parameter int unsigned LEN                  = 32,
    parameter int unsigned NB_ADDRESS_REGISTROS = 5,
    parameter int unsigned NB_WB_SEL            = 2,
    parameter int unsigned NB_LOAD_TYPE         = 3,
    parameter int unsigned NB_COUNT             = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    input  logic                            i_stall,
    input  logic                            i_flush,
    input  logic [LEN-1:0]                  i_read_data,
    input  logic [LEN-1:0]                  i_result_alu,
    input  logic [LEN-1:0]                  i_pc_plus8,
    input  logic [NB_WB_SEL-1:0]            i_wb_sel,
    input  logic [NB_LOAD_TYPE-1:0]         i_load_type,
    input  logic                            i_RegWrite,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    input  logic                            i_halt,
    output logic [LEN-1:0]                  o_write_data,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic                            o_RegWrite,
    output logic                            o_valid,
    output logic                            o_misaligned,
    output logic                            o_halted,
    output logic [NB_COUNT-1:0]             o_retired_count
);

    // MEM/WB fields
    logic                            valid_q;
    logic                            regwrite_q;
    logic                            halt_q;
    logic [LEN-1:0]                  read_data_q;
    logic [LEN-1:0]                  result_alu_q;
    logic [LEN-1:0]                  pc_plus8_q;
    logic [NB_WB_SEL-1:0]            wb_sel_q;
    logic [NB_LOAD_TYPE-1:0]         load_type_q;
    logic [NB_ADDRESS_REGISTROS-1:0] write_reg_q;

    logic                            capture;
    logic                            counted_q, counted_d;
    logic [NB_COUNT-1:0]             count_q, count_d;
    logic                            count_en;
    logic                            run_active;
    wb_state_e                       state_q, state_d;

    logic [LEN-1:0]                  ext_data;
    logic                            ext_misaligned;
    logic                            misaligned;

    assign capture = ~i_flush & ~i_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            halt_q       <= 1'b0;
            read_data_q  <= '0;
            result_alu_q <= '0;
            pc_plus8_q   <= '0;
            wb_sel_q     <= '0;
            load_type_q  <= '0;
            write_reg_q  <= '0;
        end else if (i_flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            halt_q     <= 1'b0;
        end else if (!i_stall) begin
            valid_q      <= i_valid;
            regwrite_q   <= i_RegWrite;
            halt_q       <= i_halt;
            read_data_q  <= i_read_data;
            result_alu_q <= i_result_alu;
            pc_plus8_q   <= i_pc_plus8;
            wb_sel_q     <= i_wb_sel;
            load_type_q  <= i_load_type;
            write_reg_q  <= i_write_reg;
        end
    end

    // A stall-held entry must only be counted on its first WB cycle.
    assign counted_d = capture ? 1'b0 : (counted_q | valid_q);
    assign count_en  = run_active & valid_q & ~counted_q & (count_q != {NB_COUNT{1'b1}});

    always_comb begin
        count_d = count_q;
        if (count_en) begin
            count_d = count_q + {{(NB_COUNT-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            counted_q <= 1'b0;
            count_q   <= '0;
        end else begin
            counted_q <= counted_d;
            count_q   <= count_d;
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; HALTED is left only through reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (valid_q && halt_q) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run_active = (state_q == StRun);
        o_halted   = (state_q == StHalted);
    end

    load_extract #(
        .LEN          (LEN),
        .NB_LOAD_TYPE (NB_LOAD_TYPE)
    ) u_load_extract (
        .raw_word_i   (read_data_q),
        .offset_i     (result_alu_q[1:0]),
        .load_type_i  (load_type_q),
        .data_o       (ext_data),
        .misaligned_o (ext_misaligned)
    );

    always_comb begin
        unique case (wb_sel_q)
            WB_SEL_MEM:  o_write_data = ext_data;
            WB_SEL_LINK: o_write_data = pc_plus8_q;
            default:     o_write_data = result_alu_q;
        endcase
    end

    assign misaligned      = valid_q & (wb_sel_q == WB_SEL_MEM) & ext_misaligned;
    assign o_misaligned    = misaligned;
    assign o_write_reg     = write_reg_q;
    assign o_valid         = valid_q;
    assign o_retired_count = count_q;
    assign o_RegWrite      = valid_q & regwrite_q & (write_reg_q != '0) & ~misaligned
                           & ~o_halted;

endmodule

// File: tb/tb_tl_write_back_reg.sv
module tb_tl_write_back_reg;

    localparam int CW = 4;  // narrow counter so saturation is reachable

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, stall = 1'b0, flush = 1'b0, rw = 1'b0, halt = 1'b0;
    logic [31:0] raw = '0, alu = '0, pc8 = '0;
    logic [1:0]  sel = '0;
    logic [2:0]  lt = '0;
    logic [4:0]  wr = '0;

    logic [31:0]   o_write_data;
    logic [4:0]    o_write_reg;
    logic          o_RegWrite, o_valid, o_misaligned, o_halted;
    logic [CW-1:0] o_retired_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tl_write_back_reg #(.NB_COUNT(CW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_valid         (valid),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_read_data     (raw),
        .i_result_alu    (alu),
        .i_pc_plus8      (pc8),
        .i_wb_sel        (sel),
        .i_load_type     (lt),
        .i_RegWrite      (rw),
        .i_write_reg     (wr),
        .i_halt          (halt),
        .o_write_data    (o_write_data),
        .o_write_reg     (o_write_reg),
        .o_RegWrite      (o_RegWrite),
        .o_valid         (o_valid),
        .o_misaligned    (o_misaligned),
        .o_halted        (o_halted),
        .o_retired_count (o_retired_count)
    );

    // Reference model: the instruction sitting in WB plus architectural status.
    typedef struct {
        bit        v, rw, h;
        bit [31:0] raw, alu, pc8;
        bit [1:0]  sel;
        bit [2:0]  lt;
        bit [4:0]  wr;
        int        seq;
    } entry_t;

    entry_t m;
    bit     m_halted;
    int     m_count, cap_seq, last_counted;

    function automatic void model_reset();
        m = '{v: 0, rw: 0, h: 0, raw: 0, alu: 0, pc8: 0, sel: 0, lt: 0, wr: 0, seq: -2};
        m_halted = 0;
        m_count = 0;
        cap_seq = 0;
        last_counted = -1;
    endfunction

    function automatic void model_edge();
        if (!m_halted && m.v && m.seq != last_counted) begin
            last_counted = m.seq;
            if (m_count < (1 << CW) - 1) m_count++;
        end
        if (m.v && m.h) m_halted = 1;
        if (flush) begin
            m.v = 0; m.rw = 0; m.h = 0;
        end else if (!stall) begin
            m = '{v: valid, rw: rw, h: halt, raw: raw, alu: alu, pc8: pc8, sel: sel, lt: lt,
                  wr: wr, seq: cap_seq};
            cap_seq++;
        end
    endfunction

    function automatic bit size_misaligned();
        int off;
        off = int'(m.alu[1:0]);
        if (m.lt == 3 || m.lt == 4) return (off % 2) != 0;
        if (m.lt == 1 || m.lt == 2) return 0;
        return off != 0;
    endfunction

    function automatic bit exp_mis();
        return m.v && m.sel == 2'd1 && size_misaligned();
    endfunction

    function automatic bit [31:0] exp_data();
        int        off;
        bit [31:0] b, hw;
        off = int'(m.alu[1:0]);
        b   = (m.raw >> (8 * off)) & 32'hFF;
        hw  = (m.raw >> (16 * (off / 2))) & 32'hFFFF;
        if (m.sel == 2'd2) return m.pc8;
        if (m.sel != 2'd1) return m.alu;
        if (size_misaligned()) return m.raw;
        case (m.lt)
            3'd1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd2: return b;
            3'd3: return (hw >= 32768) ? (hw | 32'hFFFF_0000) : hw;
            3'd4: return hw;
            default: return m.raw;
        endcase
    endfunction

    function automatic bit exp_we();
        return m.v && m.rw && m.wr != 0 && !exp_mis() && !m_halted;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("valid", 32'(o_valid), 32'(m.v));
        check("regwrite", 32'(o_RegWrite), 32'(exp_we()));
        check("misaligned", 32'(o_misaligned), 32'(exp_mis()));
        check("halted", 32'(o_halted), 32'(m_halted));
        check("count", 32'(o_retired_count), 32'(m_count));
        if (m.v) begin
            check("write_data", o_write_data, exp_data());
            check("write_reg", 32'(o_write_reg), 32'(m.wr));
        end else begin
            check("data_known", 32'($isunknown({o_write_data, o_write_reg})), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic put(input bit v, input bit [1:0] s, input bit [2:0] l, input bit [31:0] r,
                       input bit [31:0] a, input bit [31:0] p, input bit w, input bit [4:0] d,
                       input bit h);
        valid = v; sel = s; lt = l; raw = r; alu = a; pc8 = p; rw = w; wr = d; halt = h;
        stall = 0; flush = 0;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, then releases.
    task automatic do_reset();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_data", o_write_data, 32'd0);
        check("rst_reg", 32'(o_write_reg), 32'd0);
        check("rst_halted", 32'(o_halted), 32'd0);
        check("rst_count", 32'(o_retired_count), 32'd0);
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Byte loads at offset 1
        put(1, 2'b01, 3'd1, 32'h1234_80FF, 32'h0000_1001, 0, 1, 3, 0);
        tick();
        check("lb_data", o_write_data, 32'hFFFF_FF80);
        check("lb_we", 32'(o_RegWrite), 32'd1);
        put(1, 2'b01, 3'd2, 32'h1234_80FF, 32'h0000_1001, 0, 1, 3, 0);
        tick();
        check("lbu_data", o_write_data, 32'h0000_0080);

        // Halfword loads
        put(1, 2'b01, 3'd3, 32'h8001_0000, 32'h0000_0002, 0, 1, 4, 0);
        tick();
        check("lh_data", o_write_data, 32'hFFFF_8001);
        put(1, 2'b01, 3'd3, 32'h8001_0000, 32'h0000_0001, 0, 1, 4, 0);
        tick();
        check("lh_mis", 32'(o_misaligned), 32'd1);
        check("lh_mis_we", 32'(o_RegWrite), 32'd0);

        // Link and write to r0
        put(1, 2'b10, 3'd0, 32'h0, 32'h99, 32'h0000_0048, 1, 31, 0);
        tick();
        check("jal_data", o_write_data, 32'h0000_0048);
        check("jal_we", 32'(o_RegWrite), 32'd1);
        put(1, 2'b00, 3'd0, 32'h0, 32'h55, 32'h0, 1, 0, 0);
        tick();
        check("r0_we", 32'(o_RegWrite), 32'd0);

        // Stall three cycles with changing inputs, then flush
        put(1, 2'b00, 3'd0, 32'h0, 32'hAB, 32'h0, 1, 5, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            put(1, 2'b10, 3'd1, $urandom, $urandom, $urandom, 1, 9, 0);
            stall = 1;
            tick();
            check("stall_data", o_write_data, 32'h0000_00AB);
            check("stall_reg", 32'(o_write_reg), 32'd5);
        end
        stall = 1;
        flush = 1;
        tick();
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_we", 32'(o_RegWrite), 32'd0);
        check("stall_count", 32'(o_retired_count), 32'd7);

        // Random traffic, no HALT; counter reaches saturation
        for (int i = 0; i < 400; i++) begin
            put($urandom_range(4, 0) != 0, ($urandom_range(1, 0) != 0) ? 2'b01 : 2'($urandom),
                3'($urandom), $urandom, $urandom, $urandom, $urandom_range(3, 0) != 0,
                5'($urandom), 0);
            stall = ($urandom_range(7, 0) == 0);
            flush = ($urandom_range(9, 0) == 0);
            tick();
        end
        check("count_sat", 32'(o_retired_count), 32'd15);

        // HALT after five instructions; the HALT's own write happens
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            put(1, 2'b00, 3'd0, 0, 32'(i), 0, 1, 5'(i), 0);
            tick();
        end
        put(1, 2'b00, 3'd0, 0, 32'h77, 0, 1, 7, 1);
        tick();
        check("halt_wb_we", 32'(o_RegWrite), 32'd1);
        check("halt_wb_halted", 32'(o_halted), 32'd0);
        for (int i = 0; i < 3; i++) begin
            put(1, 2'b00, 3'd0, 0, 32'h33, 0, 1, 9, 0);
            tick();
            check("halted", 32'(o_halted), 32'd1);
            check("halted_count", 32'(o_retired_count), 32'd6);
            check("halted_we", 32'(o_RegWrite), 32'd0);
        end

        // Six instructions + HALT gives count 7, then reset mid-cycle
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            put(1, 2'b00, 3'd0, 0, 32'(i), 0, 1, 5'(i), i == 7);
            tick();
        end
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("pre_rst_halted", 32'(o_halted), 32'd1);
        check("pre_rst_count", 32'(o_retired_count), 32'd7);
        #2;
        do_reset();
        put(1, 2'b01, 3'd0, 32'hCAFE_BABE, 32'h100, 0, 1, 4, 0);
        tick();
        check("post_rst_data", o_write_data, 32'hCAFE_BABE);
        check("post_rst_we", 32'(o_RegWrite), 32'd1);
        put(1, 2'b01, 3'd4, 32'hBEEF_1234, 32'h102, 0, 1, 6, 0);
        tick();
        check("post_rst_lhu", o_write_data, 32'h0000_BEEF);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("post_rst_count", 32'(o_retired_count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
